// File: rtl/tensor_core_register_file_loader.sv
`default_nettype none
// ============================================================================
// Module      : tensor_core_register_file_loader
// Description : Accepts a valid/ready stream of ELEMENT_COUNT signed 8-bit
//               elements and writes them into a tensor-core register file
//               starting at flat register 0. Whole groups of four elements go
//               out as quad writes (quad q covers flat registers 4q..4q+3).
//               The remaining ELEMENT_COUNT mod 4 elements go out as
//               single-element (non-bulk) writes. done_out pulses once when
//               the load finishes.
// Options     : LOADER_ABORT_EN - when defined, adds abort_in. Asserting it in
//               any non-idle state returns the loader to idle. The write of
//               that cycle is suppressed, collected slots are discarded and no
//               done_out is raised.
// Ports       : clock_in, reset_in (sync, active-low)
//               start_in                          begin a load (idle only)
//               element_valid_in / element_data_in / element_ready_out
//               quad_write_enable_out / _register_address_out / _data_out
//               non_bulk_write_enable_out / _register_address_out / _data_out
//               busy_out, done_out
//               abort_in                          (LOADER_ABORT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module tensor_core_register_file_loader #(
  parameter int ELEMENT_COUNT = 18
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic                    start_in,
`ifdef LOADER_ABORT_EN
  input  logic                    abort_in,
`endif
  input  logic                    element_valid_in,
  input  logic signed [7:0]       element_data_in,
  output logic                    element_ready_out,
  output logic                    quad_write_enable_out,
  output logic [2:0]              quad_write_register_address_out,
  output logic signed [3:0][7:0]  quad_write_data_out,
  output logic                    non_bulk_write_enable_out,
  output logic [4:0]              non_bulk_write_register_address_out,
  output logic signed [7:0]       non_bulk_write_data_out,
  output logic                    busy_out,
  output logic                    done_out
);

  localparam int         FULL_QUADS = ELEMENT_COUNT / 4;
  localparam int         TAIL_COUNT = ELEMENT_COUNT % 4;
  localparam logic [2:0] LAST_QUAD  = 3'(FULL_QUADS - 1);
  localparam logic [4:0] TOTAL      = 5'(ELEMENT_COUNT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    QUAD_WR = 3'd2,
    TAIL    = 3'd3,
    TAIL_WR = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [4:0]      count;      // elements accepted so far in this load
  logic [2:0]      quad_idx;
  logic [2:0][7:0] slots;      // first three elements of the current quad
  logic            ready_q;
  logic            quad_we_q;
  logic            nb_we_q;
  logic            xfer;
  logic            abort_hit;

`ifdef LOADER_ABORT_EN
  assign abort_hit = abort_in & (state != IDLE);
  // The abort must cancel the write and the handshake in the cycle it is
  // asserted. That cancellation is the only input-to-output path, and it
  // exists only in this build option.
  assign element_ready_out         = ready_q & ~abort_in;
  assign quad_write_enable_out     = quad_we_q & ~abort_in;
  assign non_bulk_write_enable_out = nb_we_q & ~abort_in;
`else
  assign abort_hit                 = 1'b0;
  assign element_ready_out         = ready_q;
  assign quad_write_enable_out     = quad_we_q;
  assign non_bulk_write_enable_out = nb_we_q;
`endif

  assign xfer = element_valid_in & element_ready_out;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_in) next_state = (FULL_QUADS > 0) ? COLLECT : TAIL;
      COLLECT: if (xfer && count[1:0] == 2'd3) next_state = QUAD_WR;
      QUAD_WR: begin
        if (quad_idx != LAST_QUAD) next_state = COLLECT;
        else if (TAIL_COUNT > 0)   next_state = TAIL;
        else                       next_state = DONE;
      end
      TAIL:    if (xfer) next_state = TAIL_WR;
      // count already includes the element being written here
      TAIL_WR: next_state = (count != TOTAL) ? TAIL : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort_hit) next_state = IDLE;
  end

  // Control outputs are registered from next_state, so each one is high in
  // exactly the cycle its state is current.
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state                               <= IDLE;
      count                               <= '0;
      quad_idx                            <= '0;
      slots                               <= '0;
      ready_q                             <= 1'b0;
      quad_we_q                           <= 1'b0;
      nb_we_q                             <= 1'b0;
      busy_out                            <= 1'b0;
      done_out                            <= 1'b0;
      quad_write_register_address_out     <= '0;
      quad_write_data_out                 <= '0;
      non_bulk_write_register_address_out <= '0;
      non_bulk_write_data_out             <= '0;
    end else begin
      state     <= next_state;
      ready_q   <= (next_state == COLLECT) || (next_state == TAIL);
      quad_we_q <= (next_state == QUAD_WR);
      nb_we_q   <= (next_state == TAIL_WR);
      busy_out  <= (next_state != IDLE);
      done_out  <= (next_state == DONE);
      if (abort_hit) begin
        count    <= '0;
        quad_idx <= '0;
        slots    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_in) begin
              count    <= '0;
              quad_idx <= '0;
            end
          end
          COLLECT: begin
            if (xfer) begin
              count <= count + 5'd1;
              case (count[1:0])
                2'd0: slots[0] <= element_data_in;
                2'd1: slots[1] <= element_data_in;
                2'd2: slots[2] <= element_data_in;
                // Fourth element bypasses the slots straight into the quad
                default: begin
                  quad_write_register_address_out <= quad_idx;
                  quad_write_data_out <= {element_data_in, slots[2], slots[1], slots[0]};
                end
              endcase
            end
          end
          QUAD_WR: quad_idx <= quad_idx + 3'd1;
          TAIL: begin
            if (xfer) begin
              count                               <= count + 5'd1;
              // count equals 4*full_quads + tail index at this point
              non_bulk_write_register_address_out <= count;
              non_bulk_write_data_out             <= element_data_in;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
